// File: rtl/opseq_pkg.sv
// -----------------------------------------------------------------------------
// opseq_pkg
// Shared definitions for the operand pair sequencer and for any integration
// level that wires it to the ROM-operand multiply datapath.
//
// Contents:
//   opseq_state_t  - sequencer FSM state encoding (IDLE / RUN / FINISH)
//   OPSEQ_ADDR_W   - default ROM address width (also result buffer index width)
//   OPSEQ_DATA_W   - default datapath result width
//   OPSEQ_LATENCY  - default datapath latency in clock edges (legal 1..15)
//   OPSEQ_CNT_W    - width of the latency wait counter (covers 1..15)
// -----------------------------------------------------------------------------
package opseq_pkg;

  localparam int unsigned OPSEQ_ADDR_W  = 3;
  localparam int unsigned OPSEQ_DATA_W  = 8;
  localparam int unsigned OPSEQ_LATENCY = 2;
  localparam int unsigned OPSEQ_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } opseq_state_t;

endpackage : opseq_pkg

// File: rtl/opseq_result_buf.sv
// -----------------------------------------------------------------------------
// opseq_result_buf
// Result buffer of 2**ADDR_W entries x DATA_W bits with one valid bit per
// entry. Data words are never cleared; only the valid bits are, so a stale
// entry reads back its old data with rd_valid low until it is rewritten.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset (valid bits only)
//   we         in   write strobe for entry idx
//   idx        in   write index
//   data       in   write data
//   clr_valid  in   clear every valid bit
//   rd_addr    in   read index
//   rd_data    out  combinational read of entry rd_addr
//   rd_valid   out  valid bit of entry rd_addr
// -----------------------------------------------------------------------------
module opseq_result_buf
  import opseq_pkg::*;
#(
  parameter int unsigned ADDR_W = OPSEQ_ADDR_W,
  parameter int unsigned DATA_W = OPSEQ_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] data,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;

  // NOTE: the data array has no reset; the valid bits alone say whether an
  // entry holds a result, so resetting the storage would only cost logic.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= data;
    end
  end

  // The sequencer never raises clr_valid and we on the same edge, but the set
  // is ordered last so a write would still win.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else begin
      if (clr_valid) begin
        valid <= '0;
      end
      if (we) begin
        valid[idx] <= 1'b1;
      end
    end
  end

  assign rd_data  = mem[rd_addr];
  assign rd_valid = valid[rd_addr];

endmodule : opseq_result_buf

// File: rtl/operand_pair_sequencer.sv
// -----------------------------------------------------------------------------
// operand_pair_sequencer
// Control stage in front of the ROM-operand multiply datapath. A start
// request launches a run of run_len address pairs (addr1, addr1+stride),
// with both addresses stepping by one per pair. Each pair is held for
// LATENCY edges, the datapath result is captured into the result buffer,
// and a one-cycle done pulse marks the end of the run.
//
// Build option:
//   OPERAND_PAIR_SEQ_ACCUM_EN - when defined, accum keeps a running sum of the
//   captured results (cleared on every accepted start and on reset); when
//   undefined, accum is tied to zero and no adder exists.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset; aborts a run, no done pulse
//   start      in   run request, sampled only in IDLE
//   base_addr  in   first addr1 of the run (sampled with start)
//   stride     in   offset of addr2 from addr1 (sampled with start)
//   run_len    in   number of pairs, 0..2**ADDR_W (sampled with start)
//   rom_addr1  out  operand-1 ROM address (registered)
//   rom_addr2  out  operand-2 ROM address (registered)
//   result_in  in   datapath result
//   busy       out  high while a run is active
//   done       out  one-cycle pulse at run end
//   rd_addr    in   result buffer read index
//   rd_data    out  combinational read of buffer[rd_addr]
//   rd_valid   out  valid bit of buffer[rd_addr]
//   accum      out  running sum of captured results (see build option)
// -----------------------------------------------------------------------------
module operand_pair_sequencer
  import opseq_pkg::*;
#(
  parameter int unsigned ADDR_W  = OPSEQ_ADDR_W,
  parameter int unsigned DATA_W  = OPSEQ_DATA_W,
  parameter int unsigned LATENCY = OPSEQ_LATENCY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   stride,
  input  logic [ADDR_W:0]     run_len,
  output logic [ADDR_W-1:0]   rom_addr1,
  output logic [ADDR_W-1:0]   rom_addr2,
  input  logic [DATA_W-1:0]   result_in,
  output logic                busy,
  output logic                done,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic [2*DATA_W-1:0] accum
);

  localparam logic [OPSEQ_CNT_W-1:0] WAIT_INIT = OPSEQ_CNT_W'(LATENCY);

  opseq_state_t state, state_nxt;

  logic [ADDR_W-1:0]      addr1_q, addr1_nxt;
  logic [ADDR_W-1:0]      addr2_q, addr2_nxt;
  logic [ADDR_W-1:0]      idx_q, idx_nxt;
  logic [ADDR_W:0]        len_q, len_nxt;
  logic [OPSEQ_CNT_W-1:0] wait_q, wait_nxt;
  logic                   busy_q, busy_nxt;
  logic                   done_q, done_nxt;

  logic accept_start;
  logic capture;
  logic last_pair;
  logic buf_we;
  logic buf_clr;

  // len_q is at least 1 whenever RUN is active, so the subtraction never wraps
  // while the comparison matters.
  assign last_pair = ({1'b0, idx_q} == (len_q - 1'b1));

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a hold/idle default before the case,
  // so no path through the block leaves a value unassigned and no latch forms.
  always_comb begin
    state_nxt    = state;
    addr1_nxt    = addr1_q;
    addr2_nxt    = addr2_q;
    idx_nxt      = idx_q;
    len_nxt      = len_q;
    wait_nxt     = wait_q;
    busy_nxt     = busy_q;
    done_nxt     = 1'b0;
    accept_start = 1'b0;
    capture      = 1'b0;
    buf_we       = 1'b0;
    buf_clr      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          buf_clr      = 1'b1;
          if (run_len != '0) begin
            len_nxt   = run_len;
            idx_nxt   = '0;
            addr1_nxt = base_addr;
            addr2_nxt = base_addr + stride;
            wait_nxt  = WAIT_INIT;
            busy_nxt  = 1'b1;
            state_nxt = ST_RUN;
          end else begin
            // Empty run: straight to the done pulse, addresses untouched.
            state_nxt = ST_FINISH;
          end
        end
      end

      ST_RUN: begin
        wait_nxt = wait_q - 1'b1;
        if (wait_q == 1'd1) begin
          capture = 1'b1;
          buf_we  = 1'b1;
          if (last_pair) begin
            state_nxt = ST_FINISH;
          end else begin
            idx_nxt   = idx_q + 1'b1;
            addr1_nxt = addr1_q + 1'b1;
            addr2_nxt = addr2_q + 1'b1;
            wait_nxt  = WAIT_INIT;
          end
        end
      end

      ST_FINISH: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking assignments only, so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr1_q <= '0;
      addr2_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      addr1_q <= addr1_nxt;
      addr2_q <= addr2_nxt;
      idx_q   <= idx_nxt;
      len_q   <= len_nxt;
      wait_q  <= wait_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  assign rom_addr1 = addr1_q;
  assign rom_addr2 = addr2_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // ---------------------------------------------------------------------------
  // Running sum of captured results
  // ---------------------------------------------------------------------------
`ifdef OPERAND_PAIR_SEQ_ACCUM_EN
  logic [2*DATA_W-1:0] accum_q, accum_nxt;

  always_comb begin
    accum_nxt = accum_q;
    if (accept_start) begin
      accum_nxt = '0;
    end else if (capture) begin
      accum_nxt = accum_q + {{DATA_W{1'b0}}, result_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      accum_q <= '0;
    end else begin
      accum_q <= accum_nxt;
    end
  end

  assign accum = accum_q;
`else
  assign accum = '0;
`endif

  // ---------------------------------------------------------------------------
  // Result buffer
  // ---------------------------------------------------------------------------
  opseq_result_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_result_buf (
    .clk       (clk),
    .reset     (reset),
    .we        (buf_we),
    .idx       (idx_q),
    .data      (result_in),
    .clr_valid (buf_clr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );

endmodule : operand_pair_sequencer

// File: tb/tb_operand_pair_sequencer.sv
// -----------------------------------------------------------------------------
// tb_operand_pair_sequencer
// Directed bench for operand_pair_sequencer at ADDR_W=3, DATA_W=8, LATENCY=2.
// The datapath is modelled as result = rom_addr1 * rom_addr2 (mod 256) through
// one register stage, so a result is ready before the capture edge that falls
// LATENCY edges after the addresses change. Inputs change and outputs are
// sampled on the falling edge. Expected values are hand-computed constants.
// Honors OPERAND_PAIR_SEQ_ACCUM_EN for the accum expectations.
// -----------------------------------------------------------------------------
module tb_operand_pair_sequencer;

  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned LATENCY = 2;

`ifdef OPERAND_PAIR_SEQ_ACCUM_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic [ADDR_W-1:0]   stride;
  logic [ADDR_W:0]     run_len;
  logic [ADDR_W-1:0]   rom_addr1;
  logic [ADDR_W-1:0]   rom_addr2;
  logic [DATA_W-1:0]   result_in = '0;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic [2*DATA_W-1:0] accum;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int dc;

  always #5 clk = ~clk;

  operand_pair_sequencer #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LATENCY (LATENCY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .stride    (stride),
    .run_len   (run_len),
    .rom_addr1 (rom_addr1),
    .rom_addr2 (rom_addr2),
    .result_in (result_in),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .accum     (accum)
  );

  // Datapath model: ROM contents equal their address, product registered once.
  always @(posedge clk) result_in <= 8'(8'(rom_addr1) * 8'(rom_addr2));

  // Counts every cycle in which done was high.
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents start for one edge; returns at the falling edge after that edge.
  task automatic start_run(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                           input logic [ADDR_W:0] l);
    start     = 1'b1;
    base_addr = b;
    stride    = s;
    run_len   = l;
    step(1);
    start     = 1'b0;
  endtask

  task automatic check_buf(input string tag, input int idx,
                           input logic [DATA_W-1:0] exp_data, input logic exp_valid);
    rd_addr = ADDR_W'(idx);
    #1;
    check({tag, "_valid"}, 32'(rd_valid), 32'(exp_valid));
    if (exp_valid) check({tag, "_data"}, 32'(rd_data), 32'(exp_data));
  endtask

  task automatic check_all_invalid(input string tag);
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      rd_addr = ADDR_W'(i);
      #1;
      check($sformatf("%s_valid%0d", tag, i), 32'(rd_valid), 32'd0);
    end
  endtask

  task automatic check_addr(input string tag, input int a1, input int a2);
    check({tag, "_addr1"}, 32'(rom_addr1), 32'(a1));
    check({tag, "_addr2"}, 32'(rom_addr2), 32'(a2));
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    stride    = '0;
    run_len   = '0;
    rd_addr   = '0;
    step(3);

    // ---- reset state ----
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_addr("rst", 0, 0);
    check("rst_accum", 32'(accum), 32'd0);
    check_all_invalid("rst");
    reset = 1'b0;
    step(1);

    // ---- basic run: base=1 stride=1 len=3 -> (1,2),(2,3),(3,4) ----
    dc = done_cnt;
    start_run(3'd1, 3'd1, 4'd3);            // after start edge
    check("b_busy_e0", 32'(busy), 32'd1);
    check_addr("b_e0", 1, 2);
    step(1);                                // wait edge
    check_addr("b_e1", 1, 2);
    check_buf("b_e1_buf0", 0, 8'h00, 1'b0);
    step(1);                                // first capture
    check_addr("b_e2", 2, 3);
    check_buf("b_e2_buf0", 0, 8'h02, 1'b1);
    check_buf("b_e2_buf1", 1, 8'h00, 1'b0);
    step(2);                                // second capture
    check_addr("b_e4", 3, 4);
    check_buf("b_e4_buf1", 1, 8'h06, 1'b1);
    step(2);                                // third capture, addresses hold
    check_addr("b_e6", 3, 4);
    check("b_e6_busy", 32'(busy), 32'd1);
    check("b_e6_done", 32'(done), 32'd0);
    step(1);                                // done pulse
    check("b_e7_done", 32'(done), 32'd1);
    check("b_e7_busy", 32'(busy), 32'd0);
    check("b_accum", 32'(accum), ACC_EN ? 32'h14 : 32'h0);
    step(1);
    check("b_e8_done", 32'(done), 32'd0);
    check("b_done_count", 32'(done_cnt - dc), 32'd1);
    check_addr("b_idle_hold", 3, 4);
    check_buf("b_buf0", 0, 8'h02, 1'b1);
    check_buf("b_buf1", 1, 8'h06, 1'b1);
    check_buf("b_buf2", 2, 8'h0C, 1'b1);
    check_buf("b_buf3", 3, 8'h00, 1'b0);

    // ---- wrap-around: base=6 stride=3 len=4 -> (6,1),(7,2),(0,3),(1,4) ----
    start_run(3'd6, 3'd3, 4'd4);
    check_addr("w_e0", 6, 1);
    check("w_e0_accum", 32'(accum), 32'd0);
    check_all_invalid("w_e0");
    step(2);
    check_addr("w_e2", 7, 2);
    step(2);
    check_addr("w_e4", 0, 3);
    step(2);
    check_addr("w_e6", 1, 4);
    step(2);
    check("w_e8_done", 32'(done), 32'd0);
    step(1);
    check("w_e9_done", 32'(done), 32'd1);
    check_buf("w_buf0", 0, 8'h06, 1'b1);
    check_buf("w_buf1", 1, 8'h0E, 1'b1);
    check_buf("w_buf2", 2, 8'h00, 1'b1);
    check_buf("w_buf3", 3, 8'h04, 1'b1);
    check("w_accum", 32'(accum), ACC_EN ? 32'h18 : 32'h0);
    step(1);

    // ---- run_len=0: no addresses, no busy, valids cleared, done on 2nd edge ----
    dc = done_cnt;
    start_run(3'd2, 3'd2, 4'd0);
    check("z_e0_busy", 32'(busy), 32'd0);
    check("z_e0_done", 32'(done), 32'd0);
    check_addr("z_e0", 1, 4);
    check("z_accum", 32'(accum), 32'd0);
    check_all_invalid("z");
    rd_addr = 3'd1;
    #1;
    check("z_stale_data", 32'(rd_data), 32'h0E);
    step(1);
    check("z_e1_done", 32'(done), 32'd1);
    check("z_e1_busy", 32'(busy), 32'd0);
    step(1);
    check("z_e2_done", 32'(done), 32'd0);
    check("z_done_count", 32'(done_cnt - dc), 32'd1);

    // ---- start while busy is ignored: base=0 stride=2 len=2 -> (0,2),(1,3) ----
    dc = done_cnt;
    start_run(3'd0, 3'd2, 4'd2);
    check_addr("s_e0", 0, 2);
    step(1);
    start     = 1'b1;                       // sampled on the first capture edge
    base_addr = 3'd5;
    stride    = 3'd1;
    run_len   = 4'd1;
    step(1);
    start     = 1'b0;
    check_addr("s_e2", 1, 3);
    check("s_e2_busy", 32'(busy), 32'd1);
    check_buf("s_buf0", 0, 8'h00, 1'b1);
    step(2);
    check_addr("s_e4", 1, 3);
    step(1);
    check("s_e5_done", 32'(done), 32'd1);
    step(3);
    check("s_done_count", 32'(done_cnt - dc), 32'd1);
    check("s_busy_end", 32'(busy), 32'd0);
    check_buf("s_buf1", 1, 8'h03, 1'b1);
    check_buf("s_buf2", 2, 8'h00, 1'b0);

    // ---- reset mid-run after the 2nd capture: base=2 stride=1 len=4 ----
    start_run(3'd2, 3'd1, 4'd4);
    step(4);
    check_buf("r_buf1", 1, 8'h0C, 1'b1);
    reset = 1'b1;
    step(1);
    check("r_busy", 32'(busy), 32'd0);
    check("r_done", 32'(done), 32'd0);
    check_addr("r", 0, 0);
    check("r_accum", 32'(accum), 32'd0);
    check_all_invalid("r");
    dc = done_cnt;
    reset = 1'b0;
    step(4);
    check("r_no_done", 32'(done_cnt - dc), 32'd0);
    check("r_idle_busy", 32'(busy), 32'd0);

    // ---- normal run after reset: base=1 stride=2 len=1 -> (1,3) ----
    start_run(3'd1, 3'd2, 4'd1);
    check_addr("n_e0", 1, 3);
    check("n_e0_busy", 32'(busy), 32'd1);
    step(2);
    check_buf("n_buf0", 0, 8'h03, 1'b1);
    step(1);
    check("n_done", 32'(done), 32'd1);
    check("n_busy", 32'(busy), 32'd0);
    check("n_accum", 32'(accum), ACC_EN ? 32'h03 : 32'h0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_operand_pair_sequencer
